// File: rtl/cevero_mem_pkg.sv
// cevero_mem_pkg: default memory geometry plus address-decode and byte-parity helpers
package cevero_mem_pkg;
    localparam int ADDR_WIDTH_D = 32;
    localparam int DATA_WIDTH_D = 32;
    localparam int NUM_WORDS_D  = 256;

    function automatic logic [31:0] word_index(input logic [63:0] addr, input int unsigned iw);
        logic [63:0] w;
        w = (addr >> 2) & ((64'd1 << iw) - 64'd1);
        return w[31:0];
    endfunction

    function automatic logic [31:0] byte_parity(input logic [255:0] word);
        logic [31:0] p;
        for (int k = 0; k < 32; k++) p[k] = ^word[8*k+:8];
        return p;
    endfunction
endpackage

// File: rtl/cevero_sp_ram_parity.sv
// cevero_sp_ram_parity: per-byte even parity store, validity tracking and read-side compare
module cevero_sp_ram_parity
    import cevero_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_D,
    parameter int NUM_WORDS  = NUM_WORDS_D
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         we,
    input  logic                         re,
    input  logic [$clog2(NUM_WORDS)-1:0] idx,
    input  logic [DATA_WIDTH/8-1:0]      be,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [DATA_WIDTH-1:0]        rword,
    output logic                         err
);
    localparam int NB = DATA_WIDTH / 8;

    logic [NB-1:0]         mem_par [0:NUM_WORDS-1];
    logic [NUM_WORDS-1:0]  par_vld;
    logic [DATA_WIDTH-1:0] merged;

    // Parity covers the word as it will look after the byte-enabled merge.
    always_comb begin
        for (int k = 0; k < NB; k++) merged[8*k+:8] = be[k] ? wdata[8*k+:8] : rword[8*k+:8];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_vld <= '0;
            err     <= 1'b0;
        end else begin
            err <= re & par_vld[idx] & |(mem_par[idx] ^ NB'(byte_parity(256'(rword))));
            if (we) begin
                mem_par[idx] <= NB'(byte_parity(256'(merged)));
                par_vld[idx] <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/cevero_sp_ram.sv
// cevero_sp_ram: single-port word RAM with OBI req/gnt/rvalid handshake
// Define CEVERO_SP_RAM_PARITY_EN to add per-byte parity reported on err_o.
module cevero_sp_ram
    import cevero_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_D,
    parameter int DATA_WIDTH = DATA_WIDTH_D,
    parameter int NUM_WORDS  = NUM_WORDS_D
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_i,
    output logic                    gnt_o,
    output logic                    rvalid_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o
);
    localparam int IW = $clog2(NUM_WORDS);
    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [0:NUM_WORDS-1];
    logic [IW-1:0]         idx;

    assign idx   = IW'(word_index(64'(addr_i), IW));
    assign gnt_o = req_i & rst_n;

    // Storage is never reset so preloaded programs survive rst_n.
    always_ff @(posedge clk) begin
        if (gnt_o && we_i)
            for (int k = 0; k < NB; k++)
                if (be_i[k]) mem[idx][8*k+:8] <= wdata_i[8*k+:8];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= gnt_o;
            if (gnt_o && !we_i) rdata_o <= mem[idx];
        end
    end

`ifdef CEVERO_SP_RAM_PARITY_EN
    cevero_sp_ram_parity #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_WORDS (NUM_WORDS)
    ) u_parity (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (gnt_o & we_i),
        .re   (gnt_o & ~we_i),
        .idx  (idx),
        .be   (be_i),
        .wdata(wdata_i),
        .rword(mem[idx]),
        .err  (err_o)
    );
`else
    assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_cevero_sp_ram.sv
// tb_cevero_sp_ram: directed scoreboard bench for cevero_sp_ram (honours CEVERO_SP_RAM_PARITY_EN)
module tb_cevero_sp_ram;
`ifdef CEVERO_SP_RAM_PARITY_EN
    localparam logic PAR = 1'b1;
`else
    localparam logic PAR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [3:0]  be_i = '0;
    logic [31:0] wdata_i = '0;
    logic        gnt_o, rvalid_o, err_o;
    logic [31:0] rdata_o;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t        q[$];
    exp_t        x;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_rd = '0;

    always #5 clk = ~clk;

    cevero_sp_ram dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (req_i),
        .gnt_o   (gnt_o),
        .rvalid_o(rvalid_o),
        .addr_i  (addr_i),
        .we_i    (we_i),
        .be_i    (be_i),
        .wdata_i (wdata_i),
        .rdata_o (rdata_o),
        .err_o   (err_o)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (rvalid_o) begin
            if (q.size() == 0) chk("unexpected_rvalid", 32'd1, 32'd0);
            else begin
                x = q.pop_front();
                chk("rdata", rdata_o, x.d);
                chk("err", {31'b0, err_o}, {31'b0, x.e});
            end
        end
    end

    task automatic access(input logic w, input logic [31:0] a, input logic [3:0] b,
                          input logic [31:0] d, input logic [31:0] exp_d, input logic exp_e);
        @(posedge clk);
        #1;
        req_i = 1'b1; we_i = w; addr_i = a; be_i = b; wdata_i = d;
        if (w) q.push_back('{d: last_rd, e: 1'b0});
        else begin
            q.push_back('{d: exp_d, e: exp_e});
            last_rd = exp_d;
        end
        #2 chk("gnt", {31'b0, gnt_o}, 32'd1);
    endtask

    task automatic idle();
        @(posedge clk);
        #1 req_i = 1'b0;
    endtask

    initial begin
        dut.mem[0] <= 32'hDEADBEEF;
        dut.mem[1] <= 32'h00000037;
        dut.mem[2] <= 32'h11223344;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rvalid", {31'b0, rvalid_o}, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_err", {31'b0, err_o}, 32'd0);
        rst_n = 1'b1;

        access(1'b0, 32'h0, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0);
        access(1'b0, 32'h4, 4'h0, 32'h0, 32'h00000037, 1'b0);
        access(1'b1, 32'h8, 4'b0101, 32'hAABBCCDD, 32'h0, 1'b0);
        access(1'b0, 32'h8, 4'h0, 32'h0, 32'h11BB33DD, 1'b0);
        access(1'b1, 32'h403, 4'hF, 32'h5A5A5A5A, 32'h0, 1'b0);
        access(1'b0, 32'h0, 4'h0, 32'h0, 32'h5A5A5A5A, 1'b0);
        idle();
        @(posedge clk);
        #1 chk("wrap_mem0", dut.mem[0], 32'h5A5A5A5A);

        rst_n = 1'b0; req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0; wdata_i = 32'h0; be_i = 4'hF;
        last_rd = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_gnt", {31'b0, gnt_o}, 32'd0);
            chk("rst_hold_rvalid", {31'b0, rvalid_o}, 32'd0);
            chk("rst_hold_rdata", rdata_o, 32'd0);
        end
        chk("rst_mem0", dut.mem[0], 32'h5A5A5A5A);
        req_i = 1'b0; rst_n = 1'b1;

        @(posedge clk);
        #1;
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h4;
        #2 chk("pre_rst_gnt", {31'b0, gnt_o}, 32'd1);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 chk("late_rst_rvalid", {31'b0, rvalid_o}, 32'd0);
        req_i = 1'b0; rst_n = 1'b1;

        access(1'b1, 32'hC, 4'hF, 32'h01020304, 32'h0, 1'b0);
        idle();
        @(posedge clk);
        #1 dut.mem[3][0] <= 1'b1;
        access(1'b0, 32'hC, 4'h0, 32'h0, 32'h01020305, PAR);
        access(1'b0, 32'h4, 4'h0, 32'h0, 32'h00000037, 1'b0);
        idle();
        repeat (2) @(posedge clk);
        #1 chk("queue_empty", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cevero_sp_ram.md
Name: cevero_sp_ram

Overview:
- Single-port, word-organised synchronous RAM with a req/gnt/rvalid handshake.
- Serves as both the instruction and the data memory of the cevero fault-tolerant core SoC.
- Presents the OBI-style interface expected by the Ibex-derived core (instr_*/data_* buses).
- The storage array is bench-visible by hierarchy so programs can be preloaded and results inspected.

Parameters:
- ADDR_WIDTH, 32: width of addr_i (byte address).
- DATA_WIDTH, 32: word width; must be a multiple of 8.
- NUM_WORDS, 256: depth in words; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_i  in  1  access request.
- gnt_o  out  1  request accepted this cycle.
- rvalid_o  out  1  response valid; pulses one cycle after each accepted request.
- addr_i  in  ADDR_WIDTH  byte address.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  DATA_WIDTH/8  byte enables for writes; ignored for reads.
- wdata_i  in  DATA_WIDTH  write data.
- rdata_o  out  DATA_WIDTH  read data, valid while rvalid_o = 1.
- err_o  out  1  response error, valid with rvalid_o (see Optional Feature).

Behaviour:
- One clock (clk). Reset rst_n is synchronous and active-low.
- Storage:
  - Array named mem, declared [0:NUM_WORDS-1] of DATA_WIDTH bits, loadable by $readmemb/$readmemh.
  - Reset never clears mem, so preloaded contents survive reset.
- Addressing:
  - Word index = addr_i[$clog2(NUM_WORDS)+1:2].
  - addr_i[1:0] and all upper bits are ignored, so out-of-range addresses wrap. Byte address 4 maps to mem[1].
- Grant: gnt_o = req_i & rst_n, combinational. There are no wait states and a new request may be accepted every cycle.
- Write, accepted with we_i = 1: at the clock edge, each byte lane k with be_i[k] = 1 gets mem[idx][8k+7:8k] <= wdata_i[8k+7:8k]. Lanes with be_i[k] = 0 are unchanged.
- Read, accepted with we_i = 0: at the clock edge, rdata_o <= mem[idx], using the pre-write contents.
- Response:
  - rvalid_o <= accepted request (req_i & gnt_o), registered.
  - Latency is exactly one cycle for both reads and writes.
  - On a write response, rdata_o holds its previous value.
- Back-to-back accesses:
  - A write to word N followed by a read of N in the next cycle returns the new data.
  - Consecutive accepted requests produce consecutive rvalid_o pulses.
- Reset, while rst_n = 0 at an edge:
  - rvalid_o <= 0, rdata_o <= 0, err_o <= 0.
  - No write occurs and gnt_o = 0.
  - A request accepted in the cycle before reset asserts gets no response.
- Idle (req_i = 0): rvalid_o = 0 next cycle; rdata_o holds its value.

Optional Feature:
- Macro: CEVERO_SP_RAM_PARITY_EN.
- With the macro defined:
  - Add array mem_par[0:NUM_WORDS-1] of DATA_WIDTH/8 even-parity bits, plus bit vector par_vld[NUM_WORDS-1:0].
  - Reset clears par_vld.
  - Any write computes parity over the merged resulting word and sets par_vld[idx] = 1.
  - A read registers err_o <= par_vld[idx] & (any lane parity mismatch); otherwise err_o <= 0.
  - Preloaded words that have never been written never flag an error.
- Without the macro: no parity storage, and err_o is tied to 0.

Decomposition:
- Package cevero_mem_pkg holds:
  - the default ADDR_WIDTH/DATA_WIDTH/NUM_WORDS constants;
  - function word_index(addr);
  - function byte_parity(word), returning a per-byte parity vector.
- One natural sub-module, cevero_sp_ram_parity: parity generation, compare and par_vld tracking. It is instantiated only under CEVERO_SP_RAM_PARITY_EN.

Test Plan:
- Preload and read:
  - $readmemb mem[0]=0xDEADBEEF, mem[1]=0x00000037.
  - Read addr 0x0 then addr 0x4 in consecutive cycles.
  - Required: gnt_o same cycle; rvalid_o one cycle later with rdata 0xDEADBEEF, then 0x00000037; err_o = 0.
- Byte-enable write:
  - mem[2]=0x11223344; write addr 0x8, wdata 0xAABBCCDD, be 4'b0101.
  - Required: rvalid_o next cycle; a following read returns 0x11BB33DD.
- Wrap and ignored LSBs:
  - Write 0x5A5A5A5A to addr 0x403 with NUM_WORDS = 256.
  - Required: mem[0] = 0x5A5A5A5A, and a read of 0x0 returns it.
- Reset behaviour:
  - Hold rst_n = 0 with req_i = 1, we_i = 1 for 3 cycles.
  - Required: gnt_o = 0, rvalid_o = 0, rdata_o = 0, mem unchanged.
  - Reset asserted the cycle after an accepted read: no rvalid_o pulse.
- Parity (macro on):
  - Write 0x01020304 to addr 0xC, then flip mem[3][0] by hierarchy and read addr 0xC.
  - Required: err_o = 1 with rvalid_o.
  - Reading a never-written preloaded word gives err_o = 0.
- SoC smoke:
  - Two instances as instr/data memories, Fibonacci program preloaded.
  - Required: data mem[0] becomes 1 and data mem[1] holds the expected result before 1600 ns after reset release.
